// File: rtl/hzd_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Register addresses are carried zero-extended to REG_MAX_W bits.
package hzd_pkg;

  localparam int REG_MAX_W = 8;
  localparam int SEL_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [REG_MAX_W-1:0] wr_reg;
    logic                 is_load;
  } hzd_entry_t;

  function automatic int sel_w(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

  function automatic int sel_of_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hzd_match.sv
// Youngest-match priority encoder for one read port.
// Reports forward select, hit stage and whether the hit is an unready load.
module hzd_match
  import hzd_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int LOAD_RDY = 1,
  parameter int SEL_W    = sel_w(N_STAGES)
) (
  input  hzd_entry_t [N_STAGES-1:0] ent,
  input  logic                      rd_en,
  input  logic [REG_MAX_W-1:0]      rd_reg,
  output logic [SEL_W-1:0]          sel,
  output logic                      hit,
  output logic [SEL_W-1:0]          stage,
  output logic                      load_hzd
);

  // Scan oldest to youngest so the lowest index is written last and wins.
  always_comb begin
    sel      = SEL_W'(SEL_RF);
    hit      = 1'b0;
    stage    = '0;
    load_hzd = 1'b0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (rd_en && ent[k].valid && ent[k].wr_en &&
          (ent[k].wr_reg == rd_reg)) begin
        sel      = SEL_W'(sel_of_stage(k));
        hit      = 1'b1;
        stage    = SEL_W'(k);
        load_hzd = ent[k].is_load && (k < LOAD_RDY);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and load-use stall unit in ID.
// Define HZD_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int N_STAGES    = 3,
  parameter int LOAD_RDY    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = sel_w(N_STAGES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic                       id_rd_en1,
  input  logic                       id_rd_en2,
  input  logic [REG_W-1:0]           id_rd_reg1,
  input  logic [REG_W-1:0]           id_rd_reg2,
  input  logic [DATA_W-1:0]          id_rf_data1,
  input  logic [DATA_W-1:0]          id_rf_data2,
  input  logic                       id_wr_en,
  input  logic [REG_W-1:0]           id_wr_reg,
  input  logic                       id_is_load,
  input  logic                       pipe_adv,
  input  logic                       flush,
  input  logic [N_STAGES*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [SEL_W-1:0]           fwd_sel1,
  output logic [SEL_W-1:0]           fwd_sel2,
  output logic                       stall
`ifdef HZD_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  hzd_entry_t [N_STAGES-1:0] ent;
  hzd_entry_t                new_ent;

  logic             hit1, hit2;
  logic             lh1, lh2;
  logic [SEL_W-1:0] stage1, stage2;

  hzd_match #(
    .N_STAGES (N_STAGES),
    .LOAD_RDY (LOAD_RDY),
    .SEL_W    (SEL_W)
  ) u_match1 (
    .ent      (ent),
    .rd_en    (id_rd_en1),
    .rd_reg   (REG_MAX_W'(id_rd_reg1)),
    .sel      (fwd_sel1),
    .hit      (hit1),
    .stage    (stage1),
    .load_hzd (lh1)
  );

  hzd_match #(
    .N_STAGES (N_STAGES),
    .LOAD_RDY (LOAD_RDY),
    .SEL_W    (SEL_W)
  ) u_match2 (
    .ent      (ent),
    .rd_en    (id_rd_en2),
    .rd_reg   (REG_MAX_W'(id_rd_reg2)),
    .sel      (fwd_sel2),
    .hit      (hit2),
    .stage    (stage2),
    .load_hzd (lh2)
  );

  assign stall = id_valid && !flush && (lh1 || lh2);

  always_comb begin
    fwd_data1 = id_rf_data1;
    fwd_data2 = id_rf_data2;
    for (int k = 0; k < N_STAGES; k++) begin
      if (hit1 && (stage1 == SEL_W'(k)))
        fwd_data1 = stage_data[k*DATA_W +: DATA_W];
      if (hit2 && (stage2 == SEL_W'(k)))
        fwd_data2 = stage_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = id_valid && !stall && !flush;
    new_ent.wr_en   = id_wr_en;
    new_ent.wr_reg  = REG_MAX_W'(id_wr_reg);
    new_ent.is_load = id_is_load;
  end

  // A flush kills the youngest entries whether they move or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (pipe_adv) begin
      for (int k = 1; k < N_STAGES; k++) begin
        ent[k] <= ent[k-1];
        if (flush && ((k - 1) < FLUSH_DEPTH))
          ent[k].valid <= 1'b0;
      end
      ent[0] <= new_ent;
    end else if (flush) begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (k < FLUSH_DEPTH)
          ent[k].valid <= 1'b0;
      end
    end
  end

`ifdef HZD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && pipe_adv && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: default instance plus LOAD_RDY=2.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_rd_en1, id_rd_en2;
  logic [3:0]  id_rd_reg1, id_rd_reg2;
  logic [15:0] id_rf_data1, id_rf_data2;
  logic        id_wr_en;
  logic [3:0]  id_wr_reg;
  logic        id_is_load;
  logic        pipe_adv;
  logic        flush;
  logic [47:0] stage_data;

  logic [15:0] d1_a, d2_a, d1_b, d2_b;
  logic [1:0]  s1_a, s2_a, s1_b, s2_b;
  logic        st_a, st_b;
`ifdef HZD_PERF_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard u_a (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd_en1   (id_rd_en1),
    .id_rd_en2   (id_rd_en2),
    .id_rd_reg1  (id_rd_reg1),
    .id_rd_reg2  (id_rd_reg2),
    .id_rf_data1 (id_rf_data1),
    .id_rf_data2 (id_rf_data2),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_load  (id_is_load),
    .pipe_adv    (pipe_adv),
    .flush       (flush),
    .stage_data  (stage_data),
    .fwd_data1   (d1_a),
    .fwd_data2   (d2_a),
    .fwd_sel1    (s1_a),
    .fwd_sel2    (s2_a),
    .stall       (st_a)
`ifdef HZD_PERF_EN
    ,
    .stall_cnt   (scnt_a),
    .flush_cnt   (fcnt_a)
`endif
  );

  hazard_scoreboard #(.LOAD_RDY(2)) u_b (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd_en1   (id_rd_en1),
    .id_rd_en2   (id_rd_en2),
    .id_rd_reg1  (id_rd_reg1),
    .id_rd_reg2  (id_rd_reg2),
    .id_rf_data1 (id_rf_data1),
    .id_rf_data2 (id_rf_data2),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_load  (id_is_load),
    .pipe_adv    (pipe_adv),
    .flush       (flush),
    .stage_data  (stage_data),
    .fwd_data1   (d1_b),
    .fwd_data2   (d2_b),
    .fwd_sel1    (s1_b),
    .fwd_sel2    (s2_b),
    .stall       (st_b)
`ifdef HZD_PERF_EN
    ,
    .stall_cnt   (scnt_b),
    .flush_cnt   (fcnt_b)
`endif
  );

  typedef struct {
    string       nm;
    bit          b;
    bit          st;
    int          s1;
    logic [15:0] d1;
    int          s2;
    logic [15:0] d2;
    int          sc;
    int          fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0] RF1 = 16'hAAAA;
  localparam logic [15:0] RF2 = 16'hBBBB;
  localparam logic [15:0] SD0 = 16'h1111;
  localparam logic [15:0] SD1 = 16'h2222;
  localparam logic [15:0] SD2 = 16'h3333;

  task automatic set_id(input bit v, input bit e1, input int r1,
                        input bit e2, input int r2, input bit we,
                        input int wr, input bit ld);
    id_valid   = v;
    id_rd_en1  = e1;
    id_rd_reg1 = 4'(r1);
    id_rd_en2  = e2;
    id_rd_reg2 = 4'(r2);
    id_wr_en   = we;
    id_wr_reg  = 4'(wr);
    id_is_load = ld;
  endtask

  task automatic ctl(input bit adv, input bit fl, input bit r);
    pipe_adv = adv;
    flush    = fl;
    rst      = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ctl(1, 0, 0);
    repeat (n) tick();
  endtask

  task automatic chk(input string nm, input bit b, input bit st,
                     input int s1, input logic [15:0] d1,
                     input int s2, input logic [15:0] d2,
                     input int sc = -1, input int fc = -1);
    exp_t e;
    e.nm = nm; e.b = b; e.st = st;
    e.s1 = s1; e.d1 = d1; e.s2 = s2; e.d2 = d2;
    e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic        ast;
    logic [1:0]  as1, as2;
    logic [15:0] ad1, ad2;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        ast = e.b ? st_b : st_a;
        as1 = e.b ? s1_b : s1_a;
        as2 = e.b ? s2_b : s2_a;
        ad1 = e.b ? d1_b : d1_a;
        ad2 = e.b ? d2_b : d2_a;
        checks++;
        if (ast !== e.st || as1 !== 2'(e.s1) || ad1 !== e.d1 ||
            as2 !== 2'(e.s2) || ad2 !== e.d2) begin
          errors++;
          $display("FAIL %s: stall/sel1/data1/sel2/data2 got %0b/%0d/%h/%0d/%h want %0b/%0d/%h/%0d/%h",
                   e.nm, ast, as1, ad1, as2, ad2,
                   e.st, e.s1, e.d1, e.s2, e.d2);
        end
`ifdef HZD_PERF_EN
        if (e.sc >= 0) begin
          checks++;
          if (scnt_a !== 32'(e.sc) || fcnt_a !== 32'(e.fc)) begin
            errors++;
            $display("FAIL %s_cnt: stall_cnt/flush_cnt got %0d/%0d want %0d/%0d",
                     e.nm, scnt_a, fcnt_a, e.sc, e.fc);
          end
        end
`endif
      end
    end
  end

  initial begin
    id_rf_data1 = RF1;
    id_rf_data2 = RF2;
    stage_data  = {SD2, SD1, SD0};
    set_id(1, 1, 3, 1, 3, 0, 0, 0);
    ctl(1, 0, 1);
    tick();
    chk("reset", 0, 0, 0, RF1, 0, RF2, 0, 0);
    chk("reset_b", 1, 0, 0, RF1, 0, RF2);
    tick();

    // ALU result forwarded from EX
    set_id(1, 0, 0, 0, 0, 1, 3, 0);
    ctl(1, 0, 0);
    tick();
    set_id(1, 1, 3, 1, 9, 0, 0, 0);
    chk("fwd_ex", 0, 0, 1, SD0, 0, RF2);
    tick();
    idle(3);

    // load-use: one stall, bubble, then forward from MEM
    set_id(1, 0, 0, 0, 0, 1, 5, 1);
    tick();
    set_id(1, 0, 0, 1, 5, 1, 5, 0);
    chk("lu_stall", 0, 1, 0, RF1, 1, SD0);
    tick();
    chk("lu_bubble", 0, 0, 0, RF1, 2, SD1, 1, 0);
    tick();
    set_id(1, 1, 5, 0, 0, 0, 0, 0);
    chk("lu_after", 0, 0, 1, SD0, 0, RF2);
    tick();
    idle(3);

    // r4 in EX and WB, r8 in MEM; probe while frozen
    set_id(1, 0, 0, 0, 0, 1, 4, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 8, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 4, 0);
    tick();
    ctl(0, 0, 0);
    set_id(1, 1, 4, 1, 8, 0, 0, 0);
    chk("youngest", 0, 0, 1, SD0, 2, SD1);
    tick();
    set_id(1, 0, 4, 1, 4, 0, 0, 0);
    chk("rd_en_off", 0, 0, 0, RF1, 1, SD0);
    tick();
    idle(3);

    // flush beats stall and kills the youngest entry as it moves
    set_id(1, 0, 0, 0, 0, 1, 2, 1);
    tick();
    set_id(1, 1, 2, 0, 0, 1, 2, 0);
    ctl(1, 1, 0);
    chk("flush_beats", 0, 0, 1, SD0, 0, RF2);
    tick();
    set_id(1, 1, 2, 0, 0, 0, 0, 0);
    ctl(1, 0, 0);
    chk("flush_gone", 0, 0, 0, RF1, 0, RF2, 1, 1);
    tick();
    idle(3);

    // halt with a pending load hazard
    set_id(1, 0, 0, 0, 0, 1, 6, 1);
    tick();
    set_id(1, 0, 0, 1, 6, 0, 0, 0);
    ctl(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("halt", 0, 1, 0, RF1, 1, SD0, 1, 1);
      tick();
    end
    ctl(1, 0, 0);
    chk("halt_rel", 0, 1, 0, RF1, 1, SD0, 1, 1);
    tick();
    chk("halt_done", 0, 0, 0, RF1, 2, SD1, 2, 1);
    tick();
    idle(3);

    // flush during halt invalidates EX in place
    set_id(1, 0, 0, 0, 0, 1, 10, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ctl(0, 1, 0);
    chk("flush_halt", 0, 0, 0, RF1, 0, RF2);
    tick();
    set_id(1, 1, 10, 0, 0, 0, 0, 0);
    ctl(1, 0, 0);
    chk("flush_inplace", 0, 0, 0, RF1, 0, RF2, 2, 2);
    tick();
    idle(3);

    // reset while stalled
    set_id(1, 0, 0, 0, 0, 1, 11, 1);
    tick();
    set_id(1, 1, 11, 0, 0, 0, 0, 0);
    ctl(1, 0, 1);
    chk("rst_stall", 0, 1, 1, SD0, 0, RF2);
    tick();
    ctl(1, 0, 0);
    chk("rst_drop", 0, 0, 0, RF1, 0, RF2, 0, 0);
    tick();
    idle(3);

    // LOAD_RDY = 2: two stall cycles, then forward from WB
    set_id(1, 0, 0, 0, 0, 1, 7, 1);
    tick();
    set_id(1, 1, 7, 0, 0, 0, 0, 0);
    chk("lr2_s1", 1, 1, 1, SD0, 0, RF2);
    tick();
    chk("lr2_s2", 1, 1, 2, SD1, 0, RF2);
    tick();
    chk("lr2_fwd", 1, 0, 3, SD2, 0, RF2);
    tick();
    idle(2);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
